// File: rtl/regfile_dump_reader_pkg.sv
// regfile_dump_reader_pkg: shared cpu types and defaults for the register-file dump reader.
// Holds the FSM state enum, the default data/index widths and the architectural register count.
package regfile_dump_reader_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, SEND, DONE} state_e;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready output stream carrying one dumped register per word.
// Signals: out_valid (word present), out_ready (consumer accepts), out_data (register value),
// out_idx (register index), out_last (final word of the dump).
// master = producer (dump reader), slave = consumer.
interface regfile_dump_reader_if
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    modport master(output out_valid, out_data, out_idx, out_last, input out_ready);
    modport slave(input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams registers first_idx..last_idx (wrapping) out of a register file.
// Ports: clk, reset (sync, active-high); start/abort control; first_idx/last_idx range sampled
// with start; read_register/read_data combinational register-file read port; out_if output
// stream (master); busy high outside IDLE; done one-cycle pulse after the final word is accepted.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     first_idx,
    input  logic [ADDR_W-1:0]     last_idx,
    output logic [ADDR_W-1:0]     read_register,
    input  logic [DATA_W-1:0]     read_data,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master out_if
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
    logic [ADDR_W-1:0] end_idx_q, end_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_idx_q  <= '0;
            end_idx_q  <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            end_idx_q  <= end_idx_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

    // abort wins over everything in a busy state; in IDLE it also suppresses a same-cycle start
    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        end_idx_d  = end_idx_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start && !abort) begin
                    cur_idx_d = first_idx;
                    end_idx_d = last_idx;
                    state_d   = ISSUE;
                end
                ISSUE: begin
                    out_data_d = read_data;
                    out_idx_d  = cur_idx_q;
                    out_last_d = cur_idx_q == end_idx_q;
                    state_d    = SEND;
                end
                SEND: if (out_if.out_ready) begin
                    state_d   = out_last_q ? DONE : ISSUE;
                    cur_idx_d = out_last_q ? cur_idx_q : cur_idx_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign read_register    = cur_idx_q;
    assign busy             = state_q != IDLE;
    assign done             = state_q == DONE;
    assign out_if.out_valid = state_q == SEND;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_last  = out_last_q;
endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (32 registers).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 Port abort  input  1  terminate the current dump.
REQ-007 Port first_idx  input  ADDR_W  first register index; sampled with start.
REQ-008 Port last_idx  input  ADDR_W  last register index; sampled with start.
REQ-009 Port read_register  output  ADDR_W  address driven to the register file read port.
REQ-010 Port read_data  input  DATA_W  combinational read data returned by the register file.
REQ-011 Port out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-012 Port out_ready  input  1  consumer accepts the word.
REQ-013 Port out_data  output  DATA_W  captured register value.
REQ-014 Port out_idx  output  ADDR_W  index of the captured register.
REQ-015 Port out_last  output  1  word is the final word of the dump.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, SEND and DONE, encoded as a 2-bit enum.
REQ-019 IDLE: on start, latch first_idx into cur_idx and last_idx into end_idx, then go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE: drive read_register=cur_idx for one cycle.
REQ-021 ISSUE exit: at the closing edge, register read_data into out_data, cur_idx into out_idx and (cur_idx==end_idx) into out_last, then go to SEND.
REQ-022 SEND: hold out_valid=1 with out_data, out_idx and out_last stable until the cycle in which out_ready=1.
REQ-023 SEND, accepted word with out_last=1: go to DONE.
REQ-024 SEND, accepted word with out_last=0: cur_idx <= cur_idx+1 modulo 2^ADDR_W (31 wraps to 0), then go to ISSUE.
REQ-025 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-026 Throughput: one word per 2 cycles at most; latency from start to first out_valid is 2 cycles.
REQ-027 first_idx==last_idx SHALL produce exactly one word with out_last=1.
REQ-028 first_idx>last_idx SHALL wrap, producing (32-first+last+1) words.
REQ-029 start while busy SHALL be ignored.
REQ-030 abort in any non-IDLE state SHALL force IDLE at the next edge: out_valid drops and done is not pulsed.
REQ-031 abort SHALL take priority over start, and over out_ready in the same cycle.
REQ-032 read_register SHALL equal cur_idx in all states; in IDLE, cur_idx holds its last value.
REQ-033 A register-file write to the addressed register during ISSUE SHALL be reflected only as far as read_data shows it at the capturing edge; no coherency logic is provided.
REQ-034 Register 0 SHALL be read like any other index (value 0 expected).

Reset
REQ-035 On reset=1 at a rising edge: state=IDLE, cur_idx=0, end_idx=0, out_data=0, out_idx=0, out_last=0.
REQ-036 Reset SHALL hold out_valid=0, busy=0 and done=0.
REQ-037 Reset mid-dump SHALL discard the dump without a done pulse; reset has priority over abort and start.

Structure
REQ-038 The state enum and the DATA_W/ADDR_W defaults SHALL live in the shared cpu package, with the register count (32).
REQ-039 The block is a single module with no sub-modules; the output holding register is inline.

Verification
REQ-040 Full dump: preload reg k = 0x1000_0000+k; start with first=0, last=31, out_ready=1 -> 32 words with idx 0..31 and matching data, out_last only on idx 31, done exactly 1 cycle after the last accept.
REQ-041 Wrap: start with first=30, last=1 -> idx sequence 30, 31, 0, 1; out_last on idx 1; reg0 data=0.
REQ-042 Backpressure: out_ready=0 for 5 cycles on word 3 -> out_valid and out_data stable for those cycles; no word lost or duplicated.
REQ-043 Abort: abort in SEND of word 2 of a 0..7 dump -> IDLE next cycle, out_valid=0, no done; a new start then works normally.
REQ-044 Edge cases: first=last=5 gives one word, idx 5, out_last=1; start while busy is ignored; reset mid-dump leaves all outputs 0 the next cycle.
